serial_stream_bridge: RTL

//  Parametrised byte-stream bridge to the Altera_UP_Avalon_RS232 core.
//  - Drives the core's register port; the core is instantiated alongside this block.
//  - Polls the core for received bytes and buffers them in a local RX FIFO.
//  - Drains a local TX FIFO into the core, subject to its write space.
//  - User logic sees valid/ready byte streams; game logic uses it in place of ad-hoc echo FSMs.

---
 rtl/serial_stream_bridge.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_stream_bridge.sv
// serial_stream_bridge
// Byte-stream bridge to the Altera_UP_Avalon_RS232 core register port.
// Polls the core for received bytes into a local RX FIFO and drains a local
// TX FIFO into the core whenever the core reports write space. User logic
// sees plain valid/ready byte streams.
// Optional feature: define SERIAL_STREAM_BRIDGE_ECHO_EN to add an echo_en
// input that loops received bytes straight back into the TX FIFO.
module serial_stream_bridge #(
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int RESET_CYCLES = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
`ifdef SERIAL_STREAM_BRIDGE_ECHO_EN
    input  logic                        echo_en,
`endif
    output logic                        uart_reset,
    output logic                        uart_address,
    output logic                        uart_read,
    output logic                        uart_write,
    output logic [31:0]                 uart_writedata,
    input  logic [31:0]                 uart_readdata,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    localparam logic [RX_CW-1:0] RX_FULL   = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL   = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_ALMOST = TX_CW'(TX_DEPTH - 1);

    // Last cycle index of the timed states; a count of 0 or 1 still spends
    // the single cycle the state register needs to leave.
    localparam logic [15:0] RST_LAST = (RESET_CYCLES > 1) ? 16'(RESET_CYCLES - 1) : 16'd0;
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 1)   ? 16'(GAP_CYCLES - 1)   : 16'd0;

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_RX_RD,
        S_RX_CAP,
        S_WS_RD,
        S_WS_CAP,
        S_TX_WR,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic        last_rx;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;

    // Core readdata fields: data byte, RVALID flag, and the upper half
    // (RAVAIL for the data register, WSPACE for the control register).
    logic        core_rvalid;
    logic [7:0]  core_byte;
    logic [15:0] core_wspace;
    logic        unused_readdata;

    logic        cap_hit;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_elig;
    logic        tx_elig;
    logic        tx_pop;
    logic        user_push;
    logic [1:0]  tx_push_n;

    assign core_rvalid     = uart_readdata[15];
    assign core_byte       = uart_readdata[7:0];
    assign core_wspace     = uart_readdata[31:16];
    assign unused_readdata = ^uart_readdata[14:8];

    assign cap_hit = (state == S_RX_CAP) && core_rvalid;
    assign tx_elig = (tx_count != '0);
    assign tx_pop  = (state == S_TX_WR);

    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_mem[rx_rd_ptr];
    assign rx_pop   = rx_valid && rx_ready;

`ifdef SERIAL_STREAM_BRIDGE_ECHO_EN
    logic echo_push;
    logic echo_guard;

    assign echo_push = cap_hit && echo_en;
    assign rx_push   = cap_hit && !echo_en;
    assign rx_elig   = echo_en ? (tx_count < TX_FULL) : (rx_count < RX_FULL);
    // While an echo poll is in flight the last free TX slot is reserved
    // for the echoed byte, so a user push cannot steal it.
    assign echo_guard = echo_en && ((state == S_RX_RD) || (state == S_RX_CAP)) &&
                        (tx_count >= TX_ALMOST);
    assign tx_ready  = ((tx_count < TX_FULL) || tx_pop) && !echo_guard;
    assign user_push = tx_valid && tx_ready;
    assign tx_push_n = 2'(echo_push) + 2'(user_push);
`else
    assign rx_push   = cap_hit;
    assign rx_elig   = (rx_count < RX_FULL);
    assign tx_ready  = (tx_count < TX_FULL) || tx_pop;
    assign user_push = tx_valid && tx_ready;
    assign tx_push_n = {1'b0, user_push};
`endif

    // Next-state logic: timed reset hold, round-robin service, poll/capture sequences.
    always_comb begin
        state_next = state;
        case (state)
            S_RST: begin
                if (wait_cnt == RST_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rx_elig && (!tx_elig || !last_rx)) begin
                    state_next = S_RX_RD;
                end else if (tx_elig) begin
                    state_next = S_WS_RD;
                end
            end
            S_RX_RD:  state_next = S_RX_CAP;
            S_RX_CAP: state_next = S_IDLE;
            S_WS_RD:  state_next = S_WS_CAP;
            S_WS_CAP: state_next = (core_wspace != 16'd0) ? S_TX_WR : S_IDLE;
            S_TX_WR:  state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default:  state_next = S_RST;
        endcase
    end

    // State register, dwell counter for timed states, and round-robin memory.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= S_RST;
            wait_cnt <= 16'd0;
            last_rx  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next != state) ? 16'd0 : wait_cnt + 16'd1;
            if (state_next == S_RX_RD) begin
                last_rx <= 1'b1;
            end else if (state_next == S_WS_RD) begin
                last_rx <= 1'b0;
            end
        end
    end

    // Core strobes are registered from the next state so each is high
    // exactly while the FSM sits in the matching state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            uart_reset     <= 1'b1;
            uart_read      <= 1'b0;
            uart_write     <= 1'b0;
            uart_address   <= 1'b0;
            uart_writedata <= 32'd0;
        end else begin
            uart_reset     <= (state_next == S_RST);
            uart_read      <= (state_next == S_RX_RD) || (state_next == S_WS_RD);
            uart_write     <= (state_next == S_TX_WR);
            uart_address   <= (state_next == S_WS_RD);
            uart_writedata <= (state_next == S_TX_WR) ? {24'd0, tx_mem[tx_rd_ptr]} : 32'd0;
        end
    end

    // RX FIFO storage; only written when a captured byte is pushed.
    always_ff @(posedge CLOCK_50) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= core_byte;
        end
    end

    // RX FIFO pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            end
            rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
        end
    end

    // TX FIFO storage; an echoed byte lands ahead of a same-cycle user byte.
    always_ff @(posedge CLOCK_50) begin
`ifdef SERIAL_STREAM_BRIDGE_ECHO_EN
        if (echo_push) begin
            tx_mem[tx_wr_ptr] <= core_byte;
            if (user_push) begin
                tx_mem[tx_wr_ptr + TX_AW'(1)] <= tx_data;
            end
        end else if (user_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
`else
        if (user_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
`endif
    end

    // TX FIFO pointers and occupancy; the FSM pops the head in TX_WR.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            tx_wr_ptr <= tx_wr_ptr + TX_AW'(tx_push_n);
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            end
            tx_count <= tx_count + TX_CW'(tx_push_n) - TX_CW'(tx_pop);
        end
    end

endmodule
